// File: rtl/fu_seq_mult.sv
// rtl/fu_seq_mult.sv - 8x8 signed sequential shift-add multiplier FU with C/V/N/Z flags
// Optional build macro: FU_MULT_SAT_EN (saturate R on signed overflow).
module fu_seq_mult (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] R,
    output logic       C,
    output logic       V,
    output logic       N,
    output logic       Z,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] SIGN = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [2:0]  count;
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [15:0] acc;
    logic        sign;

    logic [7:0]  aMag;
    logic [7:0]  bMag;
    logic [15:0] prod;
    logic        cNext;
    logic        vNext;
    logic [7:0]  rNext;

    always_comb begin
        aMag = A[7] ? 8'(-A) : A;
        bMag = B[7] ? 8'(-B) : B;
    end

    // Sign fix and flag derivation from the accumulated magnitude
    always_comb begin
        prod  = sign ? 16'(-acc) : acc;
        cNext = |acc[15:8];
        vNext = ~((&prod[15:7]) | ~(|prod[15:7]));
`ifdef FU_MULT_SAT_EN
        if (vNext)
            rNext = sign ? 8'h80 : 8'h7F;
        else
            rNext = prod[7:0];
`else
        rNext = prod[7:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= 3'd0;
            mcand  <= 16'd0;
            mplier <= 8'd0;
            acc    <= 16'd0;
            sign   <= 1'b0;
            R      <= 8'h00;
            C      <= 1'b0;
            V      <= 1'b0;
            N      <= 1'b0;
            Z      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {8'd0, aMag};
                        mplier <= bMag;
                        sign   <= A[7] ^ B[7];
                        acc    <= 16'd0;
                        count  <= 3'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mplier <= mplier >> 1;
                    mcand  <= mcand << 1;
                    count  <= count + 3'd1;
                    if (count == 3'd7)
                        state <= SIGN;
                end
                SIGN: begin
                    R     <= rNext;
                    C     <= cNext;
                    V     <= vNext;
                    N     <= rNext[7];
                    Z     <= (rNext == 8'h00);
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_fu_seq_mult.sv
// tb/tb_fu_seq_mult.sv - self-checking bench for fu_seq_mult (vector table, random vs model, corner sequences)
module tb_fu_seq_mult;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [7:0] R;
    logic       C, V, N, Z, busy, done;

    int vectors = 0;
    int miscompares = 0;

`ifdef FU_MULT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    fu_seq_mult dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .R(R), .C(C), .V(V), .N(N), .Z(Z), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       v;
        logic       n;
        logic       z;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: true signed product, then flags from the arithmetic definitions
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b);
        int p, mag;
        logic [7:0] r;
        logic c, v;
        p   = int'($signed(a)) * int'($signed(b));
        mag = (p < 0) ? -p : p;
        c   = (mag > 255);
        v   = (p > 127) || (p < -128);
        if (SAT && v)
            r = (p > 0) ? 8'h7F : 8'h80;
        else
            r = p[7:0];
        return {r, c, v, r[7], (r == 8'h00)};
    endfunction

    task automatic doOp(input logic [7:0] a, input logic [7:0] b,
                        output logic [11:0] res, output int lat, output int busyN);
        lat = 0;
        busyN = 0;
        res = '0;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) busyN++;
            if (lat != 0) begin
                chk("done_single_cycle", done, 0);
                break;
            end
            if (done) begin
                lat = k;
                res = {R, C, V, N, Z};
            end
        end
        if (lat == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic chkRes(input string tag, input logic [11:0] got, input logic [11:0] exp);
        chk({tag, "_R"}, got[11:4], exp[11:4]);
        chk({tag, "_C"}, got[3], exp[3]);
        chk({tag, "_V"}, got[2], exp[2]);
        chk({tag, "_N"}, got[1], exp[1]);
        chk({tag, "_Z"}, got[0], exp[0]);
    endtask

    vec_t vecs[10];
    logic [11:0] res;
    int lat, busyN;
    logic [7:0] aHist[32];
    logic [7:0] bHist[32];
    int doneAt[$];
    logic [7:0] rAt[$];

    initial begin
        vecs[0] = '{8'h03, 8'h05, 8'h0F, 0, 0, 0, 0};
        vecs[1] = '{8'hFC, 8'h06, 8'hE8, 0, 0, 1, 0};
        vecs[2] = SAT ? '{8'h40, 8'h04, 8'h7F, 1, 1, 0, 0} : '{8'h40, 8'h04, 8'h00, 1, 1, 0, 1};
        vecs[3] = SAT ? '{8'h80, 8'hFF, 8'h7F, 0, 1, 0, 0} : '{8'h80, 8'hFF, 8'h80, 0, 1, 1, 0};
        vecs[4] = '{8'h00, 8'h9C, 8'h00, 0, 0, 0, 1};
        vecs[5] = SAT ? '{8'h80, 8'h80, 8'h7F, 1, 1, 0, 0} : '{8'h80, 8'h80, 8'h00, 1, 1, 0, 1};
        vecs[6] = '{8'hFF, 8'hFF, 8'h01, 0, 0, 0, 0};
        vecs[7] = '{8'h80, 8'h01, 8'h80, 0, 0, 1, 0};
        vecs[8] = SAT ? '{8'h7F, 8'h7F, 8'h7F, 1, 1, 0, 0} : '{8'h7F, 8'h7F, 8'h01, 1, 1, 0, 0};
        vecs[9] = '{8'h9C, 8'h00, 8'h00, 0, 0, 0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("rst_R", R, 0);
        chk("rst_flags", {C, V, N, Z}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        start = 1'b0;
        rst = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            doOp(vecs[i].a, vecs[i].b, res, lat, busyN);
            chk($sformatf("tbl%0d_latency", i), lat, 10);
            chk($sformatf("tbl%0d_busy_cycles", i), busyN, 10);
            chkRes($sformatf("tbl%0d", i), res,
                   {vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].n, vecs[i].z});
        end

        // Random operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 10 == 0) ra = 8'h00;
            doOp(ra, rb, res, lat, busyN);
            chk($sformatf("rnd%0d_latency", i), lat, 10);
            chkRes($sformatf("rnd%0d_%02h_%02h", i, ra, rb), res, model(ra, rb));
        end

        // start held high while operands change every cycle
        @(negedge clk);
        A = 8'h03;
        B = 8'h05;
        start = 1'b1;
        aHist[0] = A;
        bHist[0] = B;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (done) begin
                doneAt.push_back(k);
                rAt.push_back(R);
            end
            A = 8'($urandom);
            B = 8'($urandom);
            aHist[k] = A;
            bHist[k] = B;
            if (k == 22) start = 1'b0;
        end
        chk("hold_done_count", doneAt.size(), 2);
        if (doneAt.size() == 2) begin
            logic [11:0] m;
            m = model(aHist[11], bHist[11]);
            chk("hold_done0_at", doneAt[0], 10);
            chk("hold_done1_at", doneAt[1], 21);
            chk("hold_R0", rAt[0], 8'h0F);
            chk("hold_R1", rAt[1], m[11:4]);
        end

        // Reset in the middle of RUN (counter = 4)
        doOp(8'h03, 8'h05, res, lat, busyN);
        chk("pre_rst_R", res[11:4], 8'h0F);
        @(negedge clk);
        A = 8'h07;
        B = 8'h09;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_R", R, 0);
        chk("abort_flags", {C, V, N, Z}, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            chk("abort_no_done", seen, 0);
        end
        doOp(8'h02, 8'h03, res, lat, busyN);
        chk("post_rst_latency", lat, 10);
        chkRes("post_rst", res, {8'h06, 1'b0, 1'b0, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
